// File: rtl/sync_sp_ram_bw.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sync_sp_ram_bw
// Synchronous single-port RAM with byte write enables and a self-clearing
// initialisation sequence. After reset, every word is written with INIT_VAL
// (one word per cycle, ascending addresses) while busy is high. Accesses
// presented while busy is high are dropped.
//
// Parameters:
//   ADDR_WIDTH - address width, depth is 2**ADDR_WIDTH words
//   DATA_WIDTH - word width, multiple of 8
//   RD_MODE    - 0: read-first (q shows pre-write word), 1: write-first
//   INIT_VAL   - value written to every word by the clear sequence
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   cen   - chip select, active-low
//   wen   - write enable, active-low
//   be    - byte write enables, bit i covers d[8i+7:8i]
//   a     - word address
//   d     - write data
//   q     - registered read data
//   q_vld - one-cycle pulse marking q as updated
//   busy  - high while the clear sequence runs
//
// Optional feature: define SYNC_SP_RAM_BW_OUT_REG_EN to add one output
// pipeline register on q/q_vld (2-cycle latency instead of 1).
// -----------------------------------------------------------------------------
module sync_sp_ram_bw #(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    RD_MODE    = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cen,
   input  logic                    wen,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [ADDR_WIDTH-1:0]   a,
   input  logic [DATA_WIDTH-1:0]   d,
   output logic [DATA_WIDTH-1:0]   q,
   output logic                    q_vld,
   output logic                    busy
);

   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] CNT_MAX = {ADDR_WIDTH{1'b1}};

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic                    busy_q, busy_d;
   logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
   logic [DATA_WIDTH-1:0]   q_q, q_d;
   logic                    q_vld_q, q_vld_d;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    acc_s;
   logic [DATA_WIDTH-1:0]   rd_word_s;
   logic [DATA_WIDTH-1:0]   merged_s;
   logic                    mem_we_s;
   logic [ADDR_WIDTH-1:0]   mem_wa_s;
   logic [DATA_WIDTH-1:0]   mem_wd_s;

   // Clear-sequence FSM next state: walk addresses once, then park in IDLE.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      busy_d    = busy_q;
      case (state_q)
         CLEAR: begin
            if (clr_cnt_q == CNT_MAX) begin
               // Last word is written on this edge; busy falls with it.
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
               busy_d    = 1'b1;
            end
         end
         IDLE: begin
            busy_d = 1'b0;
         end
         default: begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
            busy_d    = 1'b1;
         end
      endcase
   end

   // Clear-sequence FSM state, counter and busy flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         busy_q    <= busy_d;
      end
   end

   // Access decode, byte merge and read-data next value.
   always_comb begin
      acc_s     = ~cen & ~busy_q;
      rd_word_s = mem_q[a];
      merged_s  = rd_word_s;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (be[i]) begin
            merged_s[8*i +: 8] = d[8*i +: 8];
         end else begin
            merged_s[8*i +: 8] = rd_word_s[8*i +: 8];
         end
      end
      if (acc_s) begin
         q_vld_d = 1'b1;
         if (RD_MODE == 1) begin
            q_d = merged_s;
         end else begin
            q_d = rd_word_s;
         end
      end else begin
         q_vld_d = 1'b0;
         q_d     = q_q;
      end
   end

   // Memory write port arbitration: clear sequence owns the port while busy.
   always_comb begin
      mem_we_s = 1'b0;
      mem_wa_s = a;
      mem_wd_s = merged_s;
      if (rst) begin
         mem_we_s = 1'b0;
      end else if (state_q == CLEAR) begin
         mem_we_s = 1'b1;
         mem_wa_s = clr_cnt_q;
         mem_wd_s = INIT_VAL;
      end else if (acc_s && !wen) begin
         // be all-zero rewrites the unchanged word, leaving memory intact.
         mem_we_s = 1'b1;
      end else begin
         mem_we_s = 1'b0;
      end
   end

   // Memory array; intentionally not reset, contents come from the clear pass.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[mem_wa_s] <= mem_wd_s;
      end
   end

   // First-stage read data register and valid pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q     <= '0;
         q_vld_q <= 1'b0;
      end else begin
         q_q     <= q_d;
         q_vld_q <= q_vld_d;
      end
   end

`ifdef SYNC_SP_RAM_BW_OUT_REG_EN
   logic [DATA_WIDTH-1:0] q_out_q, q_out_d;
   logic                  q_vld_out_q, q_vld_out_d;

   // Output pipeline stage feeds straight from the first stage.
   always_comb begin
      q_out_d     = q_q;
      q_vld_out_d = q_vld_q;
   end

   // Output pipeline register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_out_q     <= '0;
         q_vld_out_q <= 1'b0;
      end else begin
         q_out_q     <= q_out_d;
         q_vld_out_q <= q_vld_out_d;
      end
   end

   assign q     = q_out_q;
   assign q_vld = q_vld_out_q;
`else
   assign q     = q_q;
   assign q_vld = q_vld_q;
`endif

   assign busy = busy_q;

endmodule

// File: tb/tb_sync_sp_ram_bw.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sync_sp_ram_bw
// Two instances share stimulus: dut0 is read-first with INIT_VAL=0, dut1 is
// write-first with INIT_VAL=0xDEADBEEF. A behavioural model (word arrays plus
// a latency pipeline) predicts q, q_vld and busy after every rising edge.
// -----------------------------------------------------------------------------
module tb_sync_sp_ram_bw;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
`ifdef SYNC_SP_RAM_BW_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam logic [31:0] INIT1 = 32'hDEADBEEF;

   logic          clk = 1'b0;
   logic          rst;
   logic          cen;
   logic          wen;
   logic [3:0]    be;
   logic [AW-1:0] a;
   logic [DW-1:0] d;
   logic [DW-1:0] q0, q1;
   logic          v0, v1, b0, b1;

   sync_sp_ram_bw #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_MODE(0), .INIT_VAL(32'h0000_0000)) dut0 (
      .clk(clk), .rst(rst), .cen(cen), .wen(wen), .be(be), .a(a), .d(d),
      .q(q0), .q_vld(v0), .busy(b0)
   );

   sync_sp_ram_bw #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_MODE(1), .INIT_VAL(INIT1)) dut1 (
      .clk(clk), .rst(rst), .cen(cen), .wen(wen), .be(be), .a(a), .d(d),
      .q(q1), .q_vld(v1), .busy(b1)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] mm [2][DEPTH];
   int          clr_edges;
   bit          m_busy;
   logic [31:0] f_q [2];
   bit          f_v [2];
   logic [31:0] o_q [2];
   bit          o_v [2];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy    = 1'b1;
      clr_edges = 0;
      for (int k = 0; k < 2; k++) begin
         f_q[k] = 32'h0; f_v[k] = 1'b0;
         o_q[k] = 32'h0; o_v[k] = 1'b0;
      end
   endtask

   // Predicts the effect of one rising edge given the current inputs.
   task automatic model_edge();
      logic [31:0] mask, old, merged, nq;
      bit acc, nv;
      if (rst) begin
         model_reset();
      end else begin
         mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
         acc  = !cen && !m_busy;
         for (int k = 0; k < 2; k++) begin
            old    = mm[k][a];
            merged = (old & ~mask) | (d & mask);
            nq     = f_q[k];
            nv     = 1'b0;
            if (acc) begin
               nv = 1'b1;
               nq = (k == 1) ? merged : old;
               if (!wen) mm[k][a] = merged;
            end
            if (LAT == 2) begin
               o_q[k] = f_q[k];
               o_v[k] = f_v[k];
            end else begin
               o_q[k] = nq;
               o_v[k] = nv;
            end
            f_q[k] = nq;
            f_v[k] = nv;
         end
         if (m_busy) begin
            clr_edges++;
            if (clr_edges == DEPTH) begin
               for (int i = 0; i < DEPTH; i++) begin
                  mm[0][i] = 32'h0;
                  mm[1][i] = INIT1;
               end
               m_busy = 1'b0;
            end
         end
      end
   endtask

   task automatic check_outs();
      check_val("q0",    q0, o_q[0]);
      check_val("vld0",  {31'b0, v0}, {31'b0, o_v[0]});
      check_val("busy0", {31'b0, b0}, {31'b0, m_busy});
      check_val("q1",    q1, o_q[1]);
      check_val("vld1",  {31'b0, v1}, {31'b0, o_v[1]});
      check_val("busy1", {31'b0, b1}, {31'b0, m_busy});
   endtask

   // One clock cycle: drive on falling edge, model the rising edge, check 1ns later.
   task automatic cyc(input bit r, input bit c, input bit w, input logic [3:0] bb,
                      input logic [AW-1:0] aa, input logic [31:0] dd);
      @(negedge clk);
      rst = r; cen = c; wen = w; be = bb; a = aa; d = dd;
      @(posedge clk);
      model_edge();
      #1;
      check_outs();
   endtask

   task automatic idle(input bit r);
      cyc(r, 1'b1, 1'b1, 4'h0, 4'h0, 32'h0);
   endtask

   // Asynchronous reset assertion away from any clock edge.
   task automatic async_reset();
      rst = 1'b1;
      model_reset();
      #1;
      check_outs();
   endtask

   initial begin
      rst = 1'b1; cen = 1'b1; wen = 1'b1; be = 4'h0; a = '0; d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         mm[0][i] = 32'h0;
         mm[1][i] = 32'h0;
      end
      model_reset();
      #3;
      check_outs();
      idle(1'b1);
      idle(1'b1);

      // Release and run the clear; a write on the 3rd cycle must be dropped.
      for (int i = 0; i < DEPTH + 2; i++) begin
         if (i == 2) cyc(1'b0, 1'b0, 1'b0, 4'hF, 4'd2, 32'h0000_0055);
         else        idle(1'b0);
      end

      // Reads after clear
      cyc(1'b0, 1'b0, 1'b1, 4'h0, 4'd5, 32'h0);
      idle(1'b0);
      check_val("rd5_q0", q0, 32'h0000_0000);
      check_val("rd5_q1", q1, INIT1);
      cyc(1'b0, 1'b0, 1'b1, 4'h0, 4'd2, 32'h0);
      idle(1'b0);
      check_val("rd2_q0", q0, 32'h0000_0000);
      check_val("rd2_q1", q1, INIT1);

      // Byte-enable merge
      cyc(1'b0, 1'b0, 1'b0, 4'hF, 4'd3, 32'hAABBCCDD);
      cyc(1'b0, 1'b0, 1'b0, 4'h5, 4'd3, 32'h11223344);
      cyc(1'b0, 1'b0, 1'b1, 4'h0, 4'd3, 32'h0);
      idle(1'b0);
      check_val("merge_q0", q0, 32'hAA22CC44);
      check_val("merge_q1", q1, 32'hAA22CC44);

      // All-zero be write: accepted but memory unchanged
      cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'd3, 32'h99999999);
      cyc(1'b0, 1'b0, 1'b1, 4'h0, 4'd3, 32'h0);
      idle(1'b0);
      check_val("be0_q0", q0, 32'hAA22CC44);

      // Read-during-write ordering
      cyc(1'b0, 1'b0, 1'b0, 4'hF, 4'd7, 32'h12345678);
      idle(1'b0);
      check_val("rdw_q0", q0, 32'h0000_0000);
      check_val("rdw_q1", q1, 32'h12345678);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         cyc(1'b0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 32'($urandom));
      end

      // Reset during an access suppresses the pending q_vld
      cyc(1'b0, 1'b0, 1'b1, 4'h0, 4'd3, 32'h0);
      async_reset();
      idle(1'b1);
      for (int i = 0; i < 8; i++) idle(1'b0);

      // Reset mid-clear (counter at 8) restarts the sequence
      async_reset();
      idle(1'b1);
      for (int i = 0; i < DEPTH + 2; i++) idle(1'b0);

      // Memory fully re-cleared
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 4'h0, 4'(i), 32'h0);
      end
      for (int i = 0; i < 100; i++) begin
         cyc(1'b0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 32'($urandom));
      end
      idle(1'b0);
      idle(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
